// File: rtl/ps2_host_tx_if.sv
// Byte-request handshake between a command source and the PS/2 host transmitter.
// master = the logic that issues command bytes, slave = the transmitter itself.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_busy,
        input  tx_done,
        input  tx_error
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_busy,
        output tx_done,
        output tx_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Sends one command byte to a keyboard or
// mouse by inhibiting the bus, issuing a start bit and then shifting the
// frame out on the device-generated clock. The PS/2 lines are open-drain:
// an output enable of 1 pulls the line low, 0 releases it.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic         i_clock,
    input  logic         i_resetn,
    ps2_host_tx_if.slave tx_if,
    input  logic         i_ps2_clk_in,
    input  logic         i_ps2_data_in,
    output logic         o_ps2_clk_oe,
    output logic         o_ps2_data_oe
);

    // Both counters only ever count up to their terminal value minus one,
    // so they are sized for that range and can never wrap.
    localparam int INH_W = (INHIBIT_CYCLES > 2) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t            r_state;
    logic [9:0]        r_frame;
    logic [3:0]        r_bit_idx;
    logic [INH_W-1:0]  r_inh_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic              r_ready;
    logic              r_done;
    logic              r_error;
    logic              r_clk_oe;
    logic              r_data_oe;

    logic r_clk_meta;
    logic r_clk_sync;
    logic r_clk_prev;
    logic r_data_meta;
    logic r_data_sync;

    logic w_fall;
    logic w_accept;

    // Two-flop synchronizers for the pad inputs plus one extra clock stage
    // for falling-edge detection; idle bus level is high.
    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_clk_prev  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
        end else begin
            r_clk_meta  <= i_ps2_clk_in;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
            r_data_meta <= i_ps2_data_in;
            r_data_sync <= r_data_meta;
        end
    end

    assign w_fall   = r_clk_prev & ~r_clk_sync;
    assign w_accept = tx_if.tx_valid & r_ready;

    // Transfer sequencer. Every output is a register; tx_ready is held low
    // during the done/error pulse cycle so a new byte is only taken after it.
    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            r_state   <= S_IDLE;
            r_frame   <= '0;
            r_bit_idx <= '0;
            r_inh_cnt <= '0;
            r_to_cnt  <= '0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_error <= 1'b0;

            if (r_state == S_IDLE) begin
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
                if (w_accept) begin
                    // Odd parity: parity bit makes the count of ones odd.
                    r_frame   <= {1'b1, ~^tx_if.tx_data, tx_if.tx_data};
                    r_inh_cnt <= '0;
                    r_to_cnt  <= '0;
                    r_bit_idx <= '0;
                    r_ready   <= 1'b0;
                    r_clk_oe  <= 1'b1;
                    r_state   <= S_INHIBIT;
                end else begin
                    r_ready <= 1'b1;
                end
            end else if (r_to_cnt == TO_LAST) begin
                // Watchdog wins over anything else happening this cycle.
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
                r_error   <= 1'b1;
                r_state   <= S_IDLE;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
                case (r_state)
                    S_INHIBIT: begin
                        // Host owns the clock line here; device edges are ignored.
                        if (r_inh_cnt == INH_LAST) begin
                            r_data_oe <= 1'b1;
                            r_state   <= S_START;
                        end else begin
                            r_inh_cnt <= r_inh_cnt + 1'b1;
                        end
                    end
                    S_START: begin
                        // Release the clock with the start bit (data low) on the bus.
                        r_clk_oe  <= 1'b0;
                        r_bit_idx <= '0;
                        r_state   <= S_SEND;
                    end
                    S_SEND: begin
                        if (w_fall) begin
                            r_data_oe <= ~r_frame[r_bit_idx];
                            if (r_bit_idx == 4'd9) begin
                                r_state <= S_ACK;
                            end else begin
                                r_bit_idx <= r_bit_idx + 1'b1;
                            end
                        end
                    end
                    S_ACK: begin
                        if (w_fall) begin
                            if (!r_data_sync) begin
                                r_state <= S_WAIT_IDLE;
                            end else begin
                                r_error <= 1'b1;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (r_clk_sync && r_data_sync) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_clk_oe  <= 1'b0;
                        r_data_oe <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_if.tx_ready = r_ready;
    assign tx_if.tx_busy  = ~r_ready;
    assign tx_if.tx_done  = r_done;
    assign tx_if.tx_error = r_error;
    assign o_ps2_clk_oe   = r_clk_oe;
    assign o_ps2_data_oe  = r_data_oe;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for the PS/2 host transmitter with a simple device model:
// 40-cycle PS/2 clock, data sampled on rising edges, optional ACK.
module tb_ps2_host_tx;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic clk_oe;
    logic data_oe;
    wire  pad_clk  = ~(clk_oe | dev_clk_low);
    wire  pad_data = ~(data_oe | dev_data_low);

    ps2_host_tx_if u_if ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(8),
        .TIMEOUT_CYCLES(4000)
    ) u_dut (
        .i_clock      (clk),
        .i_resetn     (resetn),
        .tx_if        (u_if),
        .i_ps2_clk_in (pad_clk),
        .i_ps2_data_in(pad_data),
        .o_ps2_clk_oe (clk_oe),
        .o_ps2_data_oe(data_oe)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Free-running cycle count and event monitor (sampled on falling edge).
    int cyc = 0;
    int n_done = 0, n_err = 0, n_inh = 0, n_start = 0, n_acc = 0;
    int done_cyc = 0, err_cyc = 0, acc_cyc = 0;
    logic prev_ready = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u_if.tx_done)  begin n_done <= n_done + 1; done_cyc <= cyc; end
        if (u_if.tx_error) begin n_err  <= n_err + 1;  err_cyc  <= cyc; end
        if (clk_oe && !data_oe) n_inh   <= n_inh + 1;
        if (clk_oe && data_oe)  n_start <= n_start + 1;
        if (prev_ready && !u_if.tx_ready && resetn) begin
            n_acc   <= n_acc + 1;
            acc_cyc <= cyc;
        end
        prev_ready <= u_if.tx_ready;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        u_if.tx_valid = 1'b1;
        u_if.tx_data  = b;
        @(negedge clk);
        u_if.tx_valid = 1'b0;
    endtask

    // Device model: wait for the host to inhibit and release the clock, then
    // clock nclk cycles. bits[0]=start, [8:1]=data, [9]=parity, [10]=stop.
    task automatic dev_run(input int nclk, input bit ack,
                           output logic [10:0] bits, output bit ok);
        int n;
        bits = '0;
        ok = 1'b1;
        n = 0;
        while (!clk_oe && n < 200) begin @(negedge clk); n++; end
        if (!clk_oe) ok = 1'b0;
        n = 0;
        while (clk_oe && n < 200) begin @(negedge clk); n++; end
        if (clk_oe) ok = 1'b0;
        if (ok) begin
            repeat (10) @(negedge clk);
            bits[0] = pad_data;
            for (int k = 1; k <= nclk; k++) begin
                dev_clk_low = 1'b1;
                repeat (20) @(negedge clk);
                if (k == 11) dev_data_low = 1'b0;
                dev_clk_low = 1'b0;
                if (k <= 10) bits[k] = pad_data;
                if (k == 10 && ack) dev_data_low = 1'b1;
                if (k < nclk) repeat (20) @(negedge clk);
            end
        end
    endtask

    task automatic wait_cnt(input bit want_err, input int base, input int limit,
                            output bit ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (n < limit && !ok) begin
            @(negedge clk);
            n++;
            ok = want_err ? (n_err > base) : (n_done > base);
        end
    endtask

    // One full acknowledged transfer with frame and pulse checks.
    task automatic send_ack(input string tag, input logic [7:0] b,
                            input logic [10:0] exp_bits);
        logic [10:0] bits;
        bit ok;
        int bd, be;
        bd = n_done;
        be = n_err;
        start_tx(b);
        dev_run(11, 1'b1, bits, ok);
        check({tag, "_dev"}, int'(ok), 1);
        check({tag, "_bits"}, int'(bits), int'(exp_bits));
        wait_cnt(1'b0, bd, 100, ok);
        check({tag, "_done_seen"}, int'(ok), 1);
        repeat (3) @(negedge clk);
        check({tag, "_done_cnt"}, n_done - bd, 1);
        check({tag, "_err_cnt"}, n_err - be, 0);
        check({tag, "_ready"}, int'(u_if.tx_ready), 1);
        $display("tx %02h frame=%b", b, bits);
    endtask

    initial begin
        logic [10:0] bits;
        bit ok;
        int bd, be, bi, bs, ba;

        u_if.tx_valid = 1'b0;
        u_if.tx_data  = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", int'(u_if.tx_ready), 1);
        check("rst_busy", int'(u_if.tx_busy), 0);
        check("rst_oe", int'({clk_oe, data_oe}), 0);
        check("rst_pulses", int'({u_if.tx_done, u_if.tx_error}), 0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // 1: 0xED with ACK, inhibit/start timing
        bi = n_inh;
        bs = n_start;
        send_ack("ed", 8'hED, 11'b1_1_11101101_0);
        check("ed_inhibit_cycles", n_inh - bi, 8);
        check("ed_start_cycles", n_start - bs, 1);

        // 2: 0xF4 with ACK
        repeat (3) @(negedge clk);
        send_ack("f4", 8'hF4, 11'b1_0_11110100_0);

        // 3: device does not ACK
        repeat (3) @(negedge clk);
        bd = n_done;
        be = n_err;
        start_tx(8'hF4);
        dev_run(11, 1'b0, bits, ok);
        wait_cnt(1'b1, be, 100, ok);
        check("nack_err_seen", int'(ok), 1);
        repeat (3) @(negedge clk);
        check("nack_err_cnt", n_err - be, 1);
        check("nack_done_cnt", n_done - bd, 0);
        check("nack_oe", int'({clk_oe, data_oe}), 0);
        check("nack_ready", int'(u_if.tx_ready), 1);
        $display("tx f4 no-ack frame=%b", bits);

        // 4: device never clocks -> timeout
        repeat (3) @(negedge clk);
        bd = n_done;
        be = n_err;
        start_tx(8'h12);
        wait_cnt(1'b1, be, 4200, ok);
        check("to_err_seen", int'(ok), 1);
        check("to_latency", err_cyc - acc_cyc, 4000);
        repeat (2) @(negedge clk);
        check("to_err_cnt", n_err - be, 1);
        check("to_done_cnt", n_done - bd, 0);
        check("to_oe", int'({clk_oe, data_oe}), 0);
        check("to_ready", int'(u_if.tx_ready), 1);
        $display("tx 12 timeout after %0d cycles", err_cyc - acc_cyc);

        // 5: reset mid-transfer after bit 4, then a clean 0x55
        repeat (3) @(negedge clk);
        be = n_err;
        start_tx(8'h55);
        dev_run(5, 1'b0, bits, ok);
        check("mid_dev", int'(ok), 1);
        check("mid_busy_before", int'(u_if.tx_busy), 1);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("mid_rst_oe", int'({clk_oe, data_oe}), 0);
        check("mid_rst_ready", int'(u_if.tx_ready), 1);
        check("mid_rst_err", n_err - be, 0);
        $display("tx 55 aborted by reset after %0d bits", 5);
        repeat (5) @(negedge clk);
        send_ack("x55", 8'h55, 11'b1_1_01010101_0);

        // 6: tx_valid held with 0xAA during a 0xED transfer
        repeat (3) @(negedge clk);
        bd = n_done;
        ba = n_acc;
        @(negedge clk);
        u_if.tx_valid = 1'b1;
        u_if.tx_data  = 8'hED;
        @(negedge clk);
        u_if.tx_data  = 8'hAA;
        dev_run(11, 1'b1, bits, ok);
        check("hold_ed_bits", int'(bits), int'(11'b1_1_11101101_0));
        $display("tx ed (valid held) frame=%b", bits);
        wait_cnt(1'b0, bd, 100, ok);
        check("hold_ed_done", int'(ok), 1);
        for (int n = 0; n < 20 && n_acc <= ba + 1; n++) @(negedge clk);
        u_if.tx_valid = 1'b0;
        check("hold_acc_cnt", n_acc - ba, 2);
        check("hold_acc_gap", acc_cyc - done_cyc, 2);
        bd = n_done;
        dev_run(11, 1'b1, bits, ok);
        check("hold_aa_bits", int'(bits), int'(11'b1_1_10101010_0));
        wait_cnt(1'b0, bd, 100, ok);
        check("hold_aa_done", int'(ok), 1);
        $display("tx aa frame=%b", bits);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter; the other direction of the keyboard receive path (PS2_Interface).
- Sends one command byte to the keyboard or mouse, e.g. 0xED set-LEDs or 0xF4 enable.
- Sits beside the receiver in the top level. Drives the shared ps2_clock/ps2_data inouts as open-drain: an output-enable high pulls the line low, low releases it.
- The receiver ignores bus activity while tx_busy=1.

Parameters:
INHIBIT_CYCLES, 5000, cycles the clock line is held low before the request (100 us at 50 MHz)
TIMEOUT_CYCLES, 1000000, max cycles from request start to completion (20 ms at 50 MHz)

Ports:
clock  input  1  system clock (CLOCK_50 domain)
resetn  input  1  synchronous, active-low reset
tx_data  input  8  byte to send
tx_valid  input  1  send request; accepted when tx_valid & tx_ready
tx_ready  output  1  idle, can accept a byte
tx_busy  output  1  transfer in progress (~tx_ready)
tx_done  output  1  1-cycle pulse: frame sent and device ACK received
tx_error  output  1  1-cycle pulse: no ACK, or timeout
ps2_clk_in  input  1  raw ps2_clock pad value
ps2_data_in  input  1  raw ps2_data pad value
ps2_clk_oe  output  1  1 = pull ps2_clock low
ps2_data_oe  output  1  1 = pull ps2_data low

Behaviour:
- Reset (resetn=0 at a clock edge), including mid-transfer:
  - state=IDLE; tx_ready=1; tx_busy=0; tx_done=0; tx_error=0; ps2_clk_oe=0; ps2_data_oe=0.
  - Counters cleared; synchronizers set to 1.
  - The bus is released within one cycle of reset.
- Input synchronization: ps2_clk_in and ps2_data_in each pass through a 2-flop synchronizer. fall = synced clk was 1 last cycle and is 0 now.
- Frame register (10 bits), latched on accept:
  - bits 0-7 = tx_data, LSB first
  - bit 8 = odd parity = ~^tx_data
  - bit 9 = stop = 1
- IDLE: tx_ready=1. On tx_valid & tx_ready: latch frame, clear cycle counter and timeout counter, go INHIBIT. tx_valid while busy is ignored, not queued.
- INHIBIT: ps2_clk_oe=1, ps2_data_oe=0 for exactly INHIBIT_CYCLES cycles, then go START.
- START (1 cycle): ps2_clk_oe=1, ps2_data_oe=1 (start bit 0). Then go SEND with ps2_clk_oe=0 and bit_idx=0.
- SEND: ps2_data_oe keeps its value between edges. On each fall:
  - ps2_data_oe <= ~frame[bit_idx]; bit_idx++.
  - After the fall with bit_idx=9 (stop bit presented, data released), go ACK.
- ACK: on the next fall, sample synced data.
  - 0: go WAIT_IDLE.
  - 1: tx_error pulse, go IDLE.
- WAIT_IDLE: when synced clk=1 and synced data=1, go IDLE with a tx_done pulse in the same cycle.
- Timeout: the counter runs from INHIBIT entry until the return to IDLE. Reaching TIMEOUT_CYCLES in any non-IDLE state:
  - release both oe lines, tx_error pulse, go IDLE.
  - Timeout takes priority over a simultaneous fall.
- tx_done and tx_error are mutually exclusive and each lasts exactly one cycle.
- tx_ready returns to 1 in the cycle after the pulse. A new byte may be accepted in that cycle.
- Falls during INHIBIT/START are ignored; the host drives the clock then.
- Counter widths are sized from the parameters with clog2. No wrap-around is possible before timeout.

Test Plan:
Bench settings: INHIBIT_CYCLES=8, TIMEOUT_CYCLES=4000. The device model generates a PS/2 clock with a 40-cycle period, samples data on rising edges, and pulls data low for ACK.
1. Send 0xED, device ACKs -> clk_oe high for exactly 8 cycles, then both oe high 1 cycle. Device-sampled bits 0,1,0,1,1,0,1,1,1, parity 1, stop 1. tx_done pulse once, tx_error stays 0, tx_ready=1 after.
2. Send 0xF4 -> device sees data bits 0,0,1,0,1,1,1,1, parity 0, stop 1. tx_done pulse.
3. Device leaves data high at ACK edge -> tx_error pulse on 11th fall, no tx_done, both oe=0.
4. Device never generates a clock -> tx_error exactly TIMEOUT_CYCLES cycles after accept, oe lines released, back to IDLE.
5. resetn=0 for one cycle after bit 4 -> next cycle clk_oe=0, data_oe=0, tx_ready=1. A following 0x55 send completes normally with parity 1.
6. tx_valid held high with 0xAA during a 0xED transfer -> only 0xED sent. 0xAA is accepted the cycle after tx_done.
